// File: rtl/soc_mode_sequencer_pkg.sv
// soc_ctrl_pkg: shared state type, synchroniser depth and one-hot helper for soc_mode_sequencer
package soc_ctrl_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} seq_state_e;

   function automatic logic is_onehot(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/soc_mode_sequencer_if.sv
// soc_mode_sequencer_if: switch, engine handshake and status bundle of soc_mode_sequencer
interface soc_mode_sequencer_if #(
   parameter int NUM_MODES = 2
);
   logic [NUM_MODES-1:0] mode_sw_i;
   logic                 start_sw_i;
   logic [NUM_MODES-1:0] done_i;
   logic [NUM_MODES-1:0] start_o;
   logic [NUM_MODES-1:0] mode_o;
   logic                 busy_o;
   logic [NUM_MODES-1:0] led_o;
   logic                 sel_err_o;
   logic                 timeout_o;

   modport master (
      output mode_sw_i, start_sw_i, done_i,
      input  start_o, mode_o, busy_o, led_o, sel_err_o, timeout_o
   );

   modport slave (
      input  mode_sw_i, start_sw_i, done_i,
      output start_o, mode_o, busy_o, led_o, sel_err_o, timeout_o
   );
endinterface

// File: rtl/soc_mode_sequencer_sw_debounce.sv
// sw_debounce: synchronises one raw switch and accepts a change only after it is stable
module sw_debounce
   import soc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic db_o,
   output logic rise_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_db;
   logic                   r_rise;
   logic                   w_diff;
   logic                   w_flip;

   assign w_diff = r_sync[SYNC_STAGES-1] != r_db;
   assign w_flip = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign db_o   = r_db;
   assign rise_o = r_rise;

   // synchroniser shift, stability counter and debounced value with its rising-edge pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_db   <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
         r_cnt  <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
         r_db   <= w_flip ? ~r_db : r_db;
         r_rise <= w_flip && !r_db;
      end
   end
endmodule

// File: rtl/soc_mode_sequencer.sv
// soc_mode_sequencer: debounced mode/START switches drive a one-hot start pulse and track engine completion
// Optional RUN watchdog is built when SOC_MODE_SEQ_TIMEOUT_EN is defined.
module soc_mode_sequencer
   import soc_ctrl_pkg::*;
#(
   parameter int NUM_MODES       = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TIMEOUT_CYCLES  = 2**24
) (
   input logic                clk,
   input logic                rst,
   soc_mode_sequencer_if.slave io_bus
);
   seq_state_e           r_state;
   seq_state_e           w_state_nxt;
   logic [NUM_MODES-1:0] r_mode;
   logic [NUM_MODES-1:0] w_mode_nxt;
   logic [NUM_MODES-1:0] r_mode_prev;
   logic [NUM_MODES-1:0] w_mode_db;
   logic [NUM_MODES:0]   w_raw;
   logic [NUM_MODES:0]   w_db;
   logic [NUM_MODES:0]   w_rise;
   logic                 w_start_rise;
   logic                 w_sel_err;
   logic                 w_mode_chg;
   logic                 w_done;
   logic                 w_expire;

   assign w_raw = {io_bus.start_sw_i, io_bus.mode_sw_i};

   for (genvar g = 0; g <= NUM_MODES; g++) begin : g_db
      sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw_i (w_raw[g]),
         .db_o  (w_db[g]),
         .rise_o(w_rise[g])
      );
   end

   assign w_mode_db    = w_db[NUM_MODES-1:0];
   assign w_start_rise = w_rise[NUM_MODES] & w_db[NUM_MODES];
   assign w_sel_err    = !is_onehot(8'(w_mode_db));
   // rising bits come from the debouncers, falling bits from the previous debounced value
   assign w_mode_chg   = (|w_rise[NUM_MODES-1:0]) | (|(r_mode_prev & ~w_mode_db));
   assign w_done       = |(io_bus.done_i & r_mode);

`ifdef SOC_MODE_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] r_tcnt;
   logic [TW-1:0] w_tcnt_nxt;
   logic          r_timeout;
   logic          w_timeout_nxt;

   assign w_expire      = (r_state == RUN) && !w_done && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_tcnt_nxt    = (r_state == RUN) ? r_tcnt + 1'b1 : '0;
   assign w_timeout_nxt = (w_state_nxt == ARM) ? 1'b0 : (r_timeout | w_expire);

   // watchdog counts RUN cycles; the sticky flag clears when the next ARM begins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_tcnt    <= w_tcnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign io_bus.timeout_o = r_timeout;
`else
   assign w_expire         = 1'b0;
   assign io_bus.timeout_o = 1'b0;
`endif

   // state, latched mode and previous debounced mode registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_mode      <= '0;
         r_mode_prev <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode      <= w_mode_nxt;
         r_mode_prev <= w_mode_db;
      end
   end

   // next state and latched mode; switches and START are ignored while ARM/RUN
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      case (r_state)
         IDLE: begin
            if (w_start_rise && !w_sel_err) begin
               w_state_nxt = ARM;
               w_mode_nxt  = w_mode_db;
            end
         end
         ARM: w_state_nxt = RUN;
         RUN: begin
            if (w_done) begin
               w_state_nxt = DONE;
            end else if (w_expire) begin
               w_state_nxt = IDLE;
               w_mode_nxt  = '0;
            end
         end
         DONE: begin
            if (w_start_rise && !w_sel_err) begin
               w_state_nxt = ARM;
               w_mode_nxt  = w_mode_db;
            end else if (w_mode_chg) begin
               w_state_nxt = IDLE;
               w_mode_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_mode_nxt  = '0;
         end
      endcase
   end

   assign io_bus.start_o   = (r_state == ARM) ? r_mode : '0;
   assign io_bus.mode_o    = r_mode;
   assign io_bus.busy_o    = (r_state == ARM) || (r_state == RUN);
   assign io_bus.led_o     = (r_state == DONE) ? r_mode : '0;
   assign io_bus.sel_err_o = w_sel_err;
endmodule
